// File: rtl/axis_pkt_fifo_sf.sv
// Single-clock store-and-forward AXI-Stream packet FIFO.
// Only committed, good frames become visible on the master side; overflowing or bad frames are rolled back.
module axis_pkt_fifo_sf #(
    parameter int DATA_WIDTH     = 8,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH     = 9,
    parameter int DROP_BAD_FRAME = 1
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [15:0]           drop_count,
    output logic                  drop_ovf,
    output logic                  drop_bad
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int RW    = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DISC = 2'd2
    } wr_state_e;

    logic [RW-1:0]         mem [DEPTH];
    logic [RW-1:0]         ram_rdata_q;
    wr_state_e             state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         wr_commit_q, wr_commit_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         pkt_count_q, pkt_count_d;
    logic [15:0]           drop_count_q, drop_count_d;
    logic                  drop_ovf_q, drop_ovf_d;
    logic                  drop_bad_q, drop_bad_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic                  sk_valid_q, sk_valid_d;
    logic                  sk_last_q, sk_last_d;
    logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;
    logic [KEEP_WIDTH-1:0] sk_keep_q, sk_keep_d;

    logic                  full_s;
    logic                  wr_en_s;
    logic                  commit_s;
    logic                  rd_en_s;
    logic                  pop_s;
    logic                  last_hs_s;
    logic [2:0]            occ_s;

    // Write-side FSM: store beats, commit good frames, roll back dropped ones.
    always_comb begin
        full_s      = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        wr_en_s     = 1'b0;
        commit_s    = 1'b0;
        drop_ovf_d  = 1'b0;
        drop_bad_d  = 1'b0;
        if (s_axis_tvalid) begin
            case (state_q)
                ST_IDLE, ST_DATA: begin
                    if (full_s) begin
                        wr_ptr_d = wr_commit_q;
                        if (s_axis_tlast) begin
                            drop_ovf_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            state_d = ST_DISC;
                        end
                    end else begin
                        wr_en_s  = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        if (s_axis_tlast) begin
                            state_d = ST_IDLE;
                            if ((DROP_BAD_FRAME != 0) && s_axis_tuser) begin
                                wr_ptr_d   = wr_commit_q;
                                drop_bad_d = 1'b1;
                            end else begin
                                wr_commit_d = wr_ptr_q + ONE_P;
                                commit_s    = 1'b1;
                            end
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DISC: begin
                    if (s_axis_tlast) begin
                        drop_ovf_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_DISC;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = wr_commit_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Saturating drop counter.
    always_comb begin
        if ((drop_ovf_d || drop_bad_d) && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // Prefetch: issue a RAM read only if the beat is guaranteed a slot in the 2-entry output buffer.
    always_comb begin
        pop_s      = m_valid_q & m_axis_tready;
        last_hs_s  = pop_s & m_last_q;
        occ_s      = {2'b00, m_valid_q} + {2'b00, sk_valid_q} + {2'b00, rd_valid_q} - {2'b00, pop_s};
        rd_en_s    = (rd_ptr_q != wr_commit_q) && (occ_s <= 3'd1);
        rd_valid_d = rd_en_s;
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({commit_s, last_hs_s})
            2'b10:   pkt_count_d = pkt_count_q + ONE_P;
            2'b01:   pkt_count_d = pkt_count_q - ONE_P;
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    // Output register plus skid entry; the skid drains first so beat order is preserved.
    always_comb begin
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        sk_valid_d = sk_valid_q;
        sk_last_d  = sk_last_q;
        sk_data_d  = sk_data_q;
        sk_keep_d  = sk_keep_q;
        if (!m_valid_q || pop_s) begin
            if (sk_valid_q) begin
                m_valid_d  = 1'b1;
                m_last_d   = sk_last_q;
                m_data_d   = sk_data_q;
                m_keep_d   = sk_keep_q;
                sk_valid_d = rd_valid_q;
                if (rd_valid_q) begin
                    sk_last_d = ram_rdata_q[RW-1];
                    sk_keep_d = ram_rdata_q[DATA_WIDTH +: KEEP_WIDTH];
                    sk_data_d = ram_rdata_q[DATA_WIDTH-1:0];
                end else begin
                    sk_last_d = sk_last_q;
                end
            end else if (rd_valid_q) begin
                m_valid_d = 1'b1;
                m_last_d  = ram_rdata_q[RW-1];
                m_keep_d  = ram_rdata_q[DATA_WIDTH +: KEEP_WIDTH];
                m_data_d  = ram_rdata_q[DATA_WIDTH-1:0];
            end else begin
                m_valid_d = 1'b0;
            end
        end else begin
            if (rd_valid_q) begin
                sk_valid_d = 1'b1;
                sk_last_d  = ram_rdata_q[RW-1];
                sk_keep_d  = ram_rdata_q[DATA_WIDTH +: KEEP_WIDTH];
                sk_data_d  = ram_rdata_q[DATA_WIDTH-1:0];
            end else begin
                sk_valid_d = sk_valid_q;
            end
        end
    end

    // Packet RAM with registered read port.
    always_ff @(posedge axis_aclk) begin
        if (wr_en_s) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (rd_en_s) begin
            ram_rdata_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    // Control and output state registers.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= 16'd0;
            drop_ovf_q   <= 1'b0;
            drop_bad_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            sk_valid_q   <= 1'b0;
            sk_last_q    <= 1'b0;
            sk_data_q    <= '0;
            sk_keep_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            drop_ovf_q   <= drop_ovf_d;
            drop_bad_q   <= drop_bad_d;
            rd_valid_q   <= rd_valid_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            sk_valid_q   <= sk_valid_d;
            sk_last_q    <= sk_last_d;
            sk_data_q    <= sk_data_d;
            sk_keep_q    <= sk_keep_d;
        end
    end

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;
    assign drop_ovf      = drop_ovf_q;
    assign drop_bad      = drop_bad_q;

endmodule

// File: tb/tb_axis_pkt_fifo_sf.sv
// Bench for axis_pkt_fifo_sf (DEPTH=16, 8-bit data): directed scenarios plus randomized
// traffic checked against a packet-level queue model.
module tb_axis_pkt_fifo_sf;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_tdata;
    logic       s_tkeep, s_tvalid, s_tlast, s_tuser, s_tready;
    logic [7:0] m_tdata;
    logic       m_tkeep, m_tvalid, m_tlast, m_tready;
    logic [4:0] pkt_count;
    logic [15:0] drop_count;
    logic       drop_ovf, drop_bad;

    int n_cmp = 0;
    int n_bad = 0;
    int ovf_pulses = 0;
    int bad_pulses = 0;
    int exp_drops = 0;
    int good_beats_total = 0;
    bit rand_rdy = 1'b0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    axis_pkt_fifo_sf #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .ADDR_WIDTH(4), .DROP_BAD_FRAME(1)) dut (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .pkt_count(pkt_count), .drop_count(drop_count), .drop_ovf(drop_ovf), .drop_bad(drop_bad)
    );

    // Output and pulse monitor; collects only, the tasks judge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tkeep, m_tdata});
            if (drop_ovf) ovf_pulses++;
            if (drop_bad) bad_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) cyc();
    endtask

    // Drives one packet back to back (optionally with gaps); good packets go to the model queue.
    task automatic send_pkt(input int len, input logic [7:0] first, input bit rnd,
                            input bit bad, input bit gaps, input bit good);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                cyc();
            end
            s_tvalid = 1'b1;
            s_tdata  = rnd ? 8'($urandom) : first + 8'(i);
            s_tkeep  = rnd ? 1'($urandom) : 1'b1;
            s_tlast  = (i == len - 1);
            s_tuser  = (i == len - 1) ? bad : 1'($urandom);
            if (good) exp_q.push_back({s_tlast, s_tkeep, s_tdata});
            cyc();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        if (good) good_beats_total += len;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tkeep = 1'b0;
        s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        cyc();
        n_cmp++; if ({m_tvalid, m_tlast, drop_ovf, drop_bad} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_flags: got %b expected 0000", {m_tvalid, m_tlast, drop_ovf, drop_bad}); end
        n_cmp++; if ({m_tdata, m_tkeep} !== 9'h000) begin n_bad++;
            $display("FAIL reset_data: got %h expected 000", {m_tdata, m_tkeep}); end
        n_cmp++; if ({pkt_count, drop_count} !== 21'h0) begin n_bad++;
            $display("FAIL reset_counts: got pkt=%0d drop=%0d expected 0/0", pkt_count, drop_count); end
        n_cmp++; if (s_tready !== 1'b1) begin n_bad++;
            $display("FAIL reset_tready: got %b expected 1", s_tready); end
    endtask

    task automatic test_basic();
        got_q.delete(); exp_q.delete();
        send_pkt(5, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (pkt_count !== 5'd1) begin n_bad++;
            $display("FAIL basic_pktcnt_commit: got %0d expected 1", pkt_count); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++;
            $display("FAIL basic_lat_n: got tvalid %b expected 0", m_tvalid); end
        cyc();
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++;
            $display("FAIL basic_lat_n1: got tvalid %b expected 0", m_tvalid); end
        cyc();
        n_cmp++; if ({m_tvalid, m_tdata} !== 9'h101) begin n_bad++;
            $display("FAIL basic_lat_n2: got %b/%h expected 1/01", m_tvalid, m_tdata); end
        wait_beats(5, 40);
        cyc(); cyc();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++;
            $display("FAIL basic_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL basic_beat%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 10'h3ff, exp_q[i]); end
        end
        n_cmp++; if (pkt_count !== 5'd0) begin n_bad++;
            $display("FAIL basic_pktcnt_end: got %0d expected 0", pkt_count); end
    endtask

    task automatic test_single();
        got_q.delete(); exp_q.delete();
        send_pkt(1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_beats(1, 20);
        cyc(); cyc();
        n_cmp++; if (got_q.size() != 1) begin n_bad++;
            $display("FAIL single_count: got %0d beats expected 1", got_q.size()); end
        n_cmp++; if (got_q.size() < 1 || got_q[0] !== 10'h3AA) begin n_bad++;
            $display("FAIL single_beat: got %h expected 3aa", (got_q.size() > 0) ? got_q[0] : 10'h000); end
        n_cmp++; if (drop_count !== 16'd0) begin n_bad++;
            $display("FAIL single_drops: got %0d expected 0", drop_count); end
    endtask

    task automatic test_bad_frame();
        got_q.delete(); exp_q.delete(); bad_pulses = 0;
        send_pkt(6, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_drops++;
        send_pkt(3, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_beats(3, 40);
        repeat (5) cyc();
        n_cmp++; if (bad_pulses != 1) begin n_bad++;
            $display("FAIL bad_pulses: got %0d expected 1", bad_pulses); end
        n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++;
            $display("FAIL bad_dropcnt: got %0d expected %0d", drop_count, exp_drops); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++;
            $display("FAIL bad_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL bad_beat%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 10'h3ff, exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        got_q.delete(); exp_q.delete(); ovf_pulses = 0;
        m_tready = 1'b0;
        send_pkt(20, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_drops++;
        repeat (3) cyc();
        n_cmp++; if (ovf_pulses != 1) begin n_bad++;
            $display("FAIL ovf_pulses: got %0d expected 1", ovf_pulses); end
        n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++;
            $display("FAIL ovf_dropcnt: got %0d expected %0d", drop_count, exp_drops); end
        n_cmp++; if ({pkt_count, m_tvalid} !== 6'd0) begin n_bad++;
            $display("FAIL ovf_empty: got pkt=%0d tvalid=%b expected 0/0", pkt_count, m_tvalid); end
        // After rollback exactly DEPTH beats must fit.
        send_pkt(DEPTH, 8'h60, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc();
        n_cmp++; if ({pkt_count, 5'(ovf_pulses)} !== {5'd1, 5'd1}) begin n_bad++;
            $display("FAIL ovf_fullpkt: got pkt=%0d ovf=%0d expected 1/1", pkt_count, ovf_pulses); end
        m_tready = 1'b1;
        wait_beats(DEPTH, 60);
        repeat (3) cyc();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++;
            $display("FAIL ovf_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL ovf_beat%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 10'h3ff, exp_q[i]); end
        end
    endtask

    task automatic test_three_pkts();
        int lasts;
        got_q.delete(); exp_q.delete();
        m_tready = 1'b0;
        for (int p = 0; p < 3; p++) send_pkt(5, 8'(8'h80 + 8'(p * 16)), 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc();
        n_cmp++; if (pkt_count !== 5'd3) begin n_bad++;
            $display("FAIL three_pktcnt: got %0d expected 3", pkt_count); end
        ovf_pulses = 0;
        send_pkt(5, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_drops++;
        repeat (3) cyc();
        n_cmp++; if (ovf_pulses != 1 || drop_count !== 16'(exp_drops)) begin n_bad++;
            $display("FAIL three_fourth_drop: got ovf=%0d drops=%0d expected 1/%0d", ovf_pulses, drop_count, exp_drops); end
        m_tready = 1'b1;
        wait_beats(15, 80);
        repeat (10) cyc();
        lasts = 0;
        foreach (got_q[i]) if (got_q[i][9]) lasts++;
        n_cmp++; if (got_q.size() != 15 || lasts != 3) begin n_bad++;
            $display("FAIL three_out: got %0d beats %0d tlasts expected 15/3", got_q.size(), lasts); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL three_beat%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 10'h3ff, exp_q[i]); end
        end
        n_cmp++; if (pkt_count !== 5'd0) begin n_bad++;
            $display("FAIL three_pktcnt_end: got %0d expected 0", pkt_count); end
    endtask

    task automatic test_wrap();
        int pad;
        got_q.delete(); exp_q.delete();
        m_tready = 1'b1;
        pad = (14 - (good_beats_total % DEPTH) + DEPTH) % DEPTH;
        if (pad > 0) send_pkt(pad, 8'hD0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_beats(pad, 60);
        send_pkt(6, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_beats(pad + 6, 60);
        repeat (3) cyc();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++;
            $display("FAIL wrap_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL wrap_beat%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 10'h3ff, exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int len, nbad;
        bit bad;
        got_q.delete(); exp_q.delete(); bad_pulses = 0; nbad = 0;
        rand_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 8);
            bad = ($urandom_range(0, 4) == 0);
            for (int w = 0; w < 300 && (exp_q.size() - got_q.size() + len > DEPTH); w++) cyc();
            send_pkt(len, 8'h00, 1'b1, bad, 1'b1, !bad);
            if (bad) begin exp_drops++; nbad++; end
        end
        wait_beats(exp_q.size(), 1500);
        rand_rdy = 1'b0; m_tready = 1'b1;
        repeat (5) cyc();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++;
            $display("FAIL rand_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL rand_beat%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 10'h3ff, exp_q[i]); end
        end
        n_cmp++; if (bad_pulses != nbad || drop_count !== 16'(exp_drops)) begin n_bad++;
            $display("FAIL rand_drops: got pulses=%0d drops=%0d expected %0d/%0d", bad_pulses, drop_count, nbad, exp_drops); end
        n_cmp++; if (pkt_count !== 5'd0) begin n_bad++;
            $display("FAIL rand_pktcnt: got %0d expected 0", pkt_count); end
    endtask

    task automatic test_reset_mid();
        got_q.delete(); exp_q.delete();
        m_tready = 1'b0;
        send_pkt(5, 8'h51, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) cyc();
        n_cmp++; if ({m_tvalid, m_tdata, pkt_count} !== {1'b1, 8'h51, 5'd1}) begin n_bad++;
            $display("FAIL rstmid_pre: got %b/%h/%0d expected 1/51/1", m_tvalid, m_tdata, pkt_count); end
        s_tvalid = 1'b1; s_tdata = 8'h77; s_tkeep = 1'b1; s_tlast = 1'b0;
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({m_tvalid, m_tlast, m_tkeep, m_tdata, drop_ovf, drop_bad} !== 13'h0) begin n_bad++;
            $display("FAIL rstmid_out: got v=%b l=%b k=%b d=%h expected all 0", m_tvalid, m_tlast, m_tkeep, m_tdata); end
        n_cmp++; if ({pkt_count, drop_count} !== 21'h0) begin n_bad++;
            $display("FAIL rstmid_counts: got pkt=%0d drop=%0d expected 0/0", pkt_count, drop_count); end
        s_tvalid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        got_q.delete();
        m_tready = 1'b1;
        repeat (10) cyc();
        n_cmp++; if (got_q.size() != 0 || pkt_count !== 5'd0) begin n_bad++;
            $display("FAIL rstmid_stale: got %0d beats pkt=%0d expected 0/0", got_q.size(), pkt_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_bad_frame();
        test_overflow();
        test_three_pkts();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_pkt_fifo_sf.md
Name: axis_pkt_fifo_sf

Overview:
- Single-clock store-and-forward AXI-Stream packet FIFO. It is the parametrised successor of the dual-clock 8-bit packet FIFO used on the Ethernet RX path.
- Adds generic data width with tkeep, single-beat packets, bad-frame drop via tuser, atomic rollback on overflow, and drop/occupancy status.
- Sits between MAC RX and the packet parser, where only whole, good frames may reach downstream.

Parameters:
- DATA_WIDTH, 8, tdata width in bits; must be a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- ADDR_WIDTH, 9, RAM depth DEPTH = 2**ADDR_WIDTH beats.
- DROP_BAD_FRAME, 1, 1 = discard a packet whose last beat has tuser=1; 0 = ignore tuser.

Ports:
- axis_aclk  in  1  single clock for all logic
- axis_aresetn  in  1  asynchronous reset, active low
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  input end of packet
- s_axis_tuser  in  1  bad-frame flag; sampled on the tlast beat only
- s_axis_tready  out  1  tied to 1; the block never backpressures and drops instead
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output end of packet
- m_axis_tready  in  1  output ready
- pkt_count  out  ADDR_WIDTH+1  committed packets not yet fully read
- drop_count  out  16  dropped packets, saturates at 0xFFFF
- drop_ovf  out  1  one-cycle pulse when a packet is dropped for overflow
- drop_bad  out  1  one-cycle pulse when a packet is dropped for a bad frame

Behaviour:
- Reset:
  - All pointers and counters go to 0; write FSM goes to IDLE.
  - m_axis_tvalid, m_axis_tlast, drop_ovf and drop_bad are 0.
  - m_axis_tdata and m_axis_tkeep are 0.
  - Reset mid-packet discards all stored and in-flight data.
- Storage:
  - RAM width is DATA_WIDTH+KEEP_WIDTH+1; tlast is stored per beat.
  - Pointers wr_ptr, wr_commit and rd_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - used = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1). full when used == DEPTH.
  - full is computed from registered rd_ptr, so a read in the same cycle does not free space for that cycle's write.
- Write FSM, advancing on each s_axis_tvalid beat:
  - IDLE: on a beat,
    - if full, drop the beat; go to DISC if !tlast, else stay in IDLE and count the drop.
    - else write at wr_ptr and increment wr_ptr; a tlast beat goes to the commit check, otherwise go to DATA.
  - DATA: on a beat,
    - if full, roll back wr_ptr to wr_commit and go to DISC; if that beat is tlast, go to IDLE instead and count the drop.
    - else write the beat; on tlast run the commit check and go to IDLE.
  - DISC: discard beats; on tlast count an overflow drop and go to IDLE.
  - Commit check on the last beat:
    - If DROP_BAD_FRAME and tuser=1: wr_ptr <= wr_commit, drop_bad pulses, drop_count increments.
    - Otherwise: wr_commit <= wr_ptr+1, and pkt_count increments next cycle.
  - An overflow drop pulses drop_ovf and increments drop_count.
  - A packet larger than DEPTH is always dropped.
  - A single-beat packet (tvalid & tlast in IDLE) is a legal packet.
- Read side:
  - A beat is readable when rd_ptr != wr_commit; uncommitted data is never visible.
  - The RAM has 1-cycle read latency. A 2-entry output buffer/prefetch provides a registered m_axis_tvalid.
  - Sustained throughput is 1 beat/cycle while m_axis_tready=1.
  - m_axis_tvalid, tdata, tkeep and tlast hold stable while tvalid & !tready.
  - Latency: last beat accepted at edge N gives m_axis_tvalid=1 at edge N+2 (empty FIFO, tready=1).
  - pkt_count decrements on the tlast handshake. A simultaneous commit and final read leaves pkt_count unchanged.
- Wrap-around: pointers wrap naturally. A packet spanning the RAM end is contiguous at the output.

Test Plan:
- ADDR_WIDTH=4, DATA_WIDTH=8, tready=1. Send a 5-beat packet 0x01..0x05 → output 0x01..0x05, tlast on 0x05, first tvalid 2 cycles after input tlast, pkt_count 1→0.
- Single-beat packet 0xAA, tkeep=1 → one output beat with tlast=1, drop_count=0.
- 6-beat packet with tuser=1 on last beat, then a good 3-beat packet → drop_bad pulses once, drop_count=1, only the 3-beat packet is output.
- tready=0, send 20-beat packet → drop_ovf pulses once, drop_count=1, wr_ptr back to 0, no output.
- tready=0, send three 5-beat packets → pkt_count=3. Fourth packet overflows and is dropped. Release tready → exactly 15 beats out, 3 tlasts.
- Preload wr/rd pointers to 14 via earlier traffic. Send a 6-beat packet → it wraps past address 15 and is output intact. Assert axis_aresetn mid-packet → all outputs 0 and pkt_count=0 immediately.
